// File: rtl/led_scan_sequencer_if.sv
// Control and status bundle between the LED scan sequencer and its driver.
// The sequencer connects through the slave modport and the driver through the master modport.
interface led_scan_sequencer_if;
    logic       i_Enable;
    logic [1:0] i_Mode;
    logic       i_Step;
    logic       i_Load;
    logic [3:0] i_Load_Value;
    logic [3:0] o_LED_Value;
    logic       o_Dir;
    logic       o_Step_Tick;
    logic       o_Wrap;

    modport master (
        output i_Enable, i_Mode, i_Step, i_Load, i_Load_Value,
        input  o_LED_Value, o_Dir, o_Step_Tick, o_Wrap
    );

    modport slave (
        input  i_Enable, i_Mode, i_Step, i_Load, i_Load_Value,
        output o_LED_Value, o_Dir, o_Step_Tick, o_Wrap
    );
endinterface

// File: rtl/led_scan_sequencer.sv
// Generates the 4-bit LED position index. A prescaler produces step events, and the mode
// selects hold, rotate up, rotate down or bounce.
module led_scan_sequencer #(
    parameter int unsigned CLKS_PER_STEP = 10_000_000,
    parameter int unsigned CNT_WIDTH     = 24
) (
    input logic                 i_Clk,
    input logic                 i_Rst_n,
    led_scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ModeHold   = 2'b00,
        ModeUp     = 2'b01,
        ModeDown   = 2'b10,
        ModeBounce = 2'b11
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(CLKS_PER_STEP - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [3:0]           led_q;
    logic                 dir_q;
    logic                 tick_q;
    logic                 wrap_q;
    logic                 auto_step;
    logic                 step;
    mode_e                mode;

    assign mode      = mode_e'(bus.i_Mode);
    assign auto_step = bus.i_Enable && (cnt_q == CntLast);
    // A manual step coincident with an automatic one still moves the index only once.
    assign step      = auto_step || bus.i_Step;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q  <= '0;
            led_q  <= 4'd0;
            dir_q  <= 1'b1;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            if (bus.i_Load) begin
                led_q <= bus.i_Load_Value;
                cnt_q <= '0;
            end else begin
                if (bus.i_Enable) begin
                    cnt_q <= auto_step ? '0 : cnt_q + 1'b1;
                end
                if (step) begin
                    unique case (mode)
                        ModeHold: ;
                        ModeUp: begin
                            dir_q  <= 1'b1;
                            led_q  <= led_q + 4'd1;
                            tick_q <= 1'b1;
                            wrap_q <= (led_q == 4'd15);
                        end
                        ModeDown: begin
                            dir_q  <= 1'b0;
                            led_q  <= led_q - 4'd1;
                            tick_q <= 1'b1;
                            wrap_q <= (led_q == 4'd0);
                        end
                        ModeBounce: begin
                            tick_q <= 1'b1;
                            // Reverse on the end LED itself so neither end dwells.
                            if (dir_q && led_q == 4'd15) begin
                                led_q  <= 4'd14;
                                dir_q  <= 1'b0;
                                wrap_q <= 1'b1;
                            end else if (!dir_q && led_q == 4'd0) begin
                                led_q  <= 4'd1;
                                dir_q  <= 1'b1;
                                wrap_q <= 1'b1;
                            end else if (dir_q) begin
                                led_q <= led_q + 4'd1;
                            end else begin
                                led_q <= led_q - 4'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.o_LED_Value = led_q;
    assign bus.o_Dir       = dir_q;
    assign bus.o_Step_Tick = tick_q;
    assign bus.o_Wrap      = wrap_q;
endmodule

// File: doc/led_scan_sequencer.md
Name: led_scan_sequencer

Overview:
Generates the 4-bit LED position index consumed by the 16-LED one-hot display stage, and drives that stage's i_LED_Value input directly. A free-running prescaler produces step events, and each step moves the index according to a selected mode: hold, rotate up, rotate down or bounce ("scanner"). Also supports a synchronous load and a manual single-step input for button-driven demos.

Parameters:
CLKS_PER_STEP, 10_000_000, clocks between automatic steps (100 ms at 100 MHz); legal range >= 1.
CNT_WIDTH, 24, prescaler counter width; must hold CLKS_PER_STEP-1.

Ports:
i_Clk  input  1  system clock; all logic on posedge.
i_Rst_n  input  1  asynchronous active-low reset.
i_Enable  input  1  1 = prescaler runs; 0 = prescaler frozen.
i_Mode  input  2  00 hold, 01 rotate up, 10 rotate down, 11 bounce.
i_Step  input  1  single-cycle manual step request; already debounced and edge-detected upstream.
i_Load  input  1  synchronous load strobe.
i_Load_Value  input  4  index loaded when i_Load=1.
o_LED_Value  output  4  current index, registered.
o_Dir  output  1  current direction; 1 = up, 0 = down.
o_Step_Tick  output  1  one-cycle pulse, high in the cycle after o_LED_Value changed due to a step.
o_Wrap  output  1  one-cycle pulse coincident with o_Step_Tick when the step wrapped (rotate) or reversed (bounce).

Behaviour:
- Reset (asynchronous, i_Rst_n=0): o_LED_Value=0, o_Dir=1, prescaler=0, o_Step_Tick=0, o_Wrap=0. Release is synchronous to i_Clk; the first count occurs on the first edge after release.
- Prescaler: increments on each edge while i_Enable=1. When it equals CLKS_PER_STEP-1 it clears to 0 and raises the internal auto_step for that edge. While i_Enable=0 it holds its value and is not cleared.
- step = auto_step OR i_Step. If both are asserted on the same edge, exactly one step is taken.
- Priority, highest first: reset > i_Load > step.
- i_Load=1: o_LED_Value <= i_Load_Value and prescaler <= 0. A coincident step is discarded, o_Step_Tick=0 and o_Dir is unchanged.
- Step in each mode; the new value is registered on the step edge:
  - 00 hold: index unchanged; o_Step_Tick stays 0; prescaler still cycles.
  - 01 rotate up: o_Dir <= 1; index+1, with 15 -> 0 wrapping and o_Wrap=1.
  - 10 rotate down: o_Dir <= 0; index-1, with 0 -> 15 wrapping and o_Wrap=1.
  - 11 bounce:
    - o_Dir=1 and index<15: index+1.
    - o_Dir=1 and index=15: index <= 14, o_Dir <= 0, o_Wrap=1.
    - o_Dir=0 and index>0: index-1.
    - o_Dir=0 and index=0: index <= 1, o_Dir <= 1, o_Wrap=1.
    - No dwell at the ends: 15 and 0 each appear for exactly one step period.
- Mode changes take effect at the next step, with no extra latency. Entering bounce keeps the current o_Dir.
- o_Step_Tick / o_Wrap: registered and high for exactly one cycle after the step edge, except in hold mode. Both are 0 otherwise.
- Latency: step edge to new o_LED_Value is 0 cycles, since the value is registered on that edge. o_Step_Tick is aligned with the first cycle the new value is visible.
- CLKS_PER_STEP=1: auto_step fires on every enabled edge, and o_Step_Tick stays high continuously in a moving mode.
- Index arithmetic is modulo 16 on 4 bits; no out-of-range values exist.
- Reset asserted mid-step or mid-load: all state returns to reset values immediately; no partial update survives.

Test Plan:
1. CLKS_PER_STEP=4, mode 01, enable=1 after reset -> o_LED_Value advances 0,1,2,... every 4 clocks. The transition 15 -> 0 occurs at step 16 with o_Wrap=1 for one cycle; o_Step_Tick pulses 16 times in 64 clocks.
2. Mode 11, load 13, enable -> sequence 13,14,15,14,13,...,1,0,1. o_Wrap pulses at the 15 -> 14 and 0 -> 1 steps; o_Dir goes 0 after 15 and 1 after 0.
3. Mode 10, enable=0, three i_Step pulses from index 1 -> values 0, 15, 14; o_Wrap on the 0 -> 15 step; prescaler stays at its frozen value.
4. i_Step asserted on the same edge as auto_step, index 5, mode 01 -> index 6 (not 7) and a single o_Step_Tick. Separately, i_Load=1 (value 9) coincident with a step -> index 9, o_Step_Tick=0, prescaler=0.
5. Mode 00 with enable=1 for 20 clocks at index 7 -> index stays 7 and o_Step_Tick stays 0. Switch to mode 01 -> the first step yields 8.
6. Assert i_Rst_n=0 mid-period at index 11, o_Dir=0, asynchronously between clock edges -> outputs go to 0/1/0/0 before the next edge. After release, the first step occurs exactly CLKS_PER_STEP enabled clocks later.
